// File: rtl/udp_frame_scheduler.sv
// Decides when a frame leaves the AD sample buffer for the UDP TX path. A frame goes out
// when a full frame is buffered, or as a partial frame after the level sits idle. Then an inter-frame gap.
module udp_frame_scheduler #(
    parameter int FRAME_BYTES = 1024,
    parameter int MIN_BYTES   = 18,
    parameter int TIMEOUT_CYC = 125000,
    parameter int IFG_CYC     = 12,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] fifo_rd_cnt,
    input  logic             tx_req,
    input  logic             tx_done,
    output logic             frame_tx_start,
    output logic [15:0]      rd_byte_num,
    output logic             busy,
    output logic             len_err,
    input  logic             err_clr
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_GAP} state_t;

    localparam logic [31:0] FRAME_L  = 32'(FRAME_BYTES);
    localparam logic [31:0] MIN_L    = 32'(MIN_BYTES);
    localparam logic [31:0] TO_LAST  = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
    localparam logic [31:0] IFG_LAST = (IFG_CYC > 0) ? 32'(IFG_CYC - 1) : 32'd0;

    state_t      state_q, state_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] beat_q, beat_d, beat_inc;
    logic [15:0] rd_byte_num_q, rd_byte_num_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        len_err_q, len_err_d;
    logic [31:0] level;

    assign level = 32'(fifo_rd_cnt);
    // Beat count as it stands including this cycle's request; saturates rather than wraps.
    assign beat_inc = (tx_req && beat_q != 16'hFFFF) ? beat_q + 16'd1 : beat_q;

    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        beat_d        = beat_q;
        rd_byte_num_d = rd_byte_num_q;
        start_d       = 1'b0;
        busy_d        = busy_q;
        len_err_d     = err_clr ? 1'b0 : len_err_q;
        case (state_q)
            S_IDLE: begin
                if (level >= FRAME_L) begin
                    rd_byte_num_d = 16'(FRAME_BYTES);
                    to_cnt_d      = 32'd0;
                    start_d       = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = S_START;
                end else if (level >= MIN_L) begin
                    if (to_cnt_q >= TO_LAST) begin
                        rd_byte_num_d = 16'(fifo_rd_cnt);
                        to_cnt_d      = 32'd0;
                        start_d       = 1'b1;
                        busy_d        = 1'b1;
                        state_d       = S_START;
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end else begin
                    to_cnt_d = 32'd0;
                end
            end
            S_START: state_d = S_SEND;
            S_SEND: begin
                beat_d = beat_inc;
                if (tx_done) begin
                    if (beat_inc != rd_byte_num_q) len_err_d = 1'b1;
                    beat_d    = 16'd0;
                    gap_cnt_d = 32'd0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q >= IFG_LAST) begin
                    gap_cnt_d = 32'd0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            to_cnt_q      <= 32'd0;
            gap_cnt_q     <= 32'd0;
            beat_q        <= 16'd0;
            rd_byte_num_q <= 16'(FRAME_BYTES);
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            beat_q        <= beat_d;
            rd_byte_num_q <= rd_byte_num_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            len_err_q     <= len_err_d;
        end
    end

    assign frame_tx_start = start_q;
    assign rd_byte_num    = rd_byte_num_q;
    assign busy           = busy_q;
    assign len_err        = len_err_q;
endmodule

// File: tb/tb_udp_frame_scheduler.sv
// Directed bench for udp_frame_scheduler: a per-cycle vector table for full frames,
// length errors and gap timing, plus hand sequences for timeout and mid-frame reset.
module tb_udp_frame_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] fifo_rd_cnt;
    logic        tx_req, tx_done, err_clr;
    logic        frame_tx_start;
    logic [15:0] rd_byte_num;
    logic        busy, len_err;

    int n_checks = 0;
    int n_err    = 0;

    udp_frame_scheduler #(
        .FRAME_BYTES(1024), .MIN_BYTES(18), .TIMEOUT_CYC(50), .IFG_CYC(12), .CNT_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo_rd_cnt(fifo_rd_cnt), .tx_req(tx_req),
        .tx_done(tx_done), .frame_tx_start(frame_tx_start), .rd_byte_num(rd_byte_num),
        .busy(busy), .len_err(len_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          reps;
        logic [11:0] fifo;
        logic        req;
        logic        done;
        logic        clr;
        logic        exp_start;
        logic        exp_busy;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic s, input logic b,
                              input logic [15:0] rd, input logic e);
        check({tag, ".start"}, 32'(frame_tx_start), 32'(s));
        check({tag, ".busy"},  32'(busy),           32'(b));
        check({tag, ".rd"},    32'(rd_byte_num),    32'(rd));
        check({tag, ".err"},   32'(len_err),        32'(e));
    endtask

    initial begin
        // reps, fifo, req, done, clr -> start, busy, rd, err
        vecs[0]  = '{1,    12'd1024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1024, 1'b0};
        vecs[1]  = '{1,    12'd1024, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b0};
        vecs[2]  = '{1023, 12'd1024, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b0};
        vecs[3]  = '{1,    12'd1024, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b0};
        vecs[4]  = '{11,   12'd1024, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b0};
        vecs[5]  = '{1,    12'd1024, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1024, 1'b0};
        vecs[6]  = '{1,    12'd1024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1024, 1'b0};
        vecs[7]  = '{1,    12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b0};
        vecs[8]  = '{999,  12'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b0};
        vecs[9]  = '{1,    12'd0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b1};
        vecs[10] = '{11,   12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b1};
        vecs[11] = '{1,    12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1024, 1'b1};
        vecs[12] = '{3,    12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1024, 1'b1};
        vecs[13] = '{1,    12'd0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1024, 1'b0};
        vecs[14] = '{1,    12'd1024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1024, 1'b0};
        vecs[15] = '{1,    12'd1024, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b0};
        vecs[16] = '{9,    12'd1024, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b0};
        vecs[17] = '{1,    12'd0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1024, 1'b1};
        vecs[18] = '{11,   12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1024, 1'b1};
        vecs[19] = '{1,    12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1024, 1'b1};

        rst_n = 1'b0; fifo_rd_cnt = '0; tx_req = 1'b0; tx_done = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, 16'd1024, 1'b0);
        check("reset.to_cnt", dut.to_cnt_q, 32'd0);
        #4 rst_n = 1'b1;

        // Level one below MIN_BYTES never arms the timeout.
        fifo_rd_cnt = 12'd17;
        for (int i = 0; i < 200; i++) begin
            tick();
            check("below_min.start", 32'(frame_tx_start), 32'd0);
            check("below_min.to_cnt", dut.to_cnt_q, 32'd0);
        end
        fifo_rd_cnt = 12'd18;
        tick();
        check("at_min.to_cnt", dut.to_cnt_q, 32'd1);

        for (int v = 0; v < NV; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                fifo_rd_cnt = vecs[v].fifo;
                tx_req      = vecs[v].req;
                tx_done     = vecs[v].done;
                err_clr     = vecs[v].clr;
                tick();
                check_outs($sformatf("vec%0d", v), vecs[v].exp_start, vecs[v].exp_busy,
                           vecs[v].exp_rd, vecs[v].exp_err);
            end
        end
        tx_req = 1'b0; tx_done = 1'b0; err_clr = 1'b0;

        // Timeout: a dip below MIN_BYTES restarts the 50-cycle wait.
        fifo_rd_cnt = 12'd100;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("timeout_a.start", 32'(frame_tx_start), 32'd0);
        end
        fifo_rd_cnt = 12'd5;
        tick();
        check("timeout_dip.to_cnt", dut.to_cnt_q, 32'd0);
        fifo_rd_cnt = 12'd100;
        for (int i = 0; i < 49; i++) begin
            tick();
            check("timeout_b.start", 32'(frame_tx_start), 32'd0);
        end
        tick();
        check_outs("timeout_fire", 1'b1, 1'b1, 16'd100, 1'b1);
        fifo_rd_cnt = 12'd0;
        tick();
        check_outs("timeout_send", 1'b0, 1'b1, 16'd100, 1'b1);
        tx_req = 1'b1;
        repeat (99) tick();
        tx_done = 1'b1;
        tick();
        tx_req = 1'b0; tx_done = 1'b0;
        check_outs("timeout_done", 1'b0, 1'b1, 16'd100, 1'b1);
        repeat (12) tick();
        check_outs("timeout_gap_end", 1'b0, 1'b0, 16'd100, 1'b1);

        // Mid-frame asynchronous reset, then a fresh start on release.
        fifo_rd_cnt = 12'd60;
        repeat (49) tick();
        check("part60.pre", 32'(frame_tx_start), 32'd0);
        tick();
        check_outs("part60.fire", 1'b1, 1'b1, 16'd60, 1'b1);
        tick();
        tx_req = 1'b1;
        repeat (3) tick();
        check_outs("part60.send", 1'b0, 1'b1, 16'd60, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 1'b0, 1'b0, 16'd1024, 1'b0);
        tx_req = 1'b0;
        fifo_rd_cnt = 12'd1024;
        repeat (2) tick();
        check_outs("rst_held", 1'b0, 1'b0, 16'd1024, 1'b0);
        #4 rst_n = 1'b1;
        tick();
        check_outs("rst_release", 1'b1, 1'b1, 16'd1024, 1'b0);
        tick();
        check_outs("rst_release_send", 1'b0, 1'b1, 16'd1024, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
